// File: rtl/redundancy_pkg.sv
// Shared definitions for the redundancy scanner: default parameters,
// the FILL/ISSUE/HANDOFF state encoding and a lane-counter width helper.
// Optional build macro used by the scanner: RSCAN_FLUSH_EN (adds flush_in).
package redundancy_pkg;

  localparam int DEF_WORD_WIDTH = 8;
  localparam int DEF_ITER_WIDTH = 9;
  localparam int DEF_STEP_RANGE = 128;

  localparam logic [1:0] ST_FILL    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_HANDOFF = 2'd2;

  // The lane counter must be able to hold the value "all lanes filled".
  function automatic int lane_cnt_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/window_matcher.sv
// Combinational comparator: reports whether the incoming word equals any
// of the stored words whose lane is marked filled.
module window_matcher #(
  parameter int WORD_WIDTH = 8,
  parameter int LANES      = 128
) (
  input  logic [WORD_WIDTH-1:0]       word,
  input  logic [LANES*WORD_WIDTH-1:0] stored_words,
  input  logic [LANES-1:0]            fill_mask,
  output logic                        match
);

  // OR-reduce the per-lane equality results of the filled lanes only.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (fill_mask[i] && (stored_words[i*WORD_WIDTH +: WORD_WIDTH] == word)) begin
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/redundancy_scanner.sv
// Redundancy scanner: collects a batch of words into lanes, classifies each
// lane as redundant (word seen earlier in the batch) or unique, then hands
// the batch to a free-list controller with an available/enable handshake.
// Build macro RSCAN_FLUSH_EN adds flush_in for issuing partial batches.
module redundancy_scanner
  import redundancy_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int ITER_WIDTH = DEF_ITER_WIDTH,
  parameter int STEP_RANGE = DEF_STEP_RANGE
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  input  logic [WORD_WIDTH-1:0]            in_word,
  output logic                             in_ready,
  input  logic                             ctrl_available,
`ifdef RSCAN_FLUSH_EN
  input  logic                             flush_in,
`endif
  output logic                             enable_out,
  output logic [STEP_RANGE-1:0]            fl_enable_ch,
  output logic [STEP_RANGE*ITER_WIDTH-1:0] fl_it_out,
  output logic [STEP_RANGE-1:0]            nr_enable_ch,
  output logic [STEP_RANGE*ITER_WIDTH-1:0] nr_it_out
);

  localparam int LANE_W = lane_cnt_width(STEP_RANGE);

  logic [1:0]                        state;
  logic [LANE_W-1:0]                 lane_cnt;
  logic [ITER_WIDTH-1:0]             iter_cnt;
  logic [STEP_RANGE*WORD_WIDTH-1:0]  lane_words;
  logic [STEP_RANGE-1:0]             filled;
  logic [STEP_RANGE-1:0]             fl_mask;
  logic [STEP_RANGE-1:0]             nr_mask;
  logic [STEP_RANGE*ITER_WIDTH-1:0]  lane_iters;
  logic                              accept;
  logic                              match;
  logic                              flush_req;

`ifdef RSCAN_FLUSH_EN
  assign flush_req = flush_in;
`else
  assign flush_req = 1'b0;
`endif

  assign in_ready = (state == ST_FILL);
  assign accept   = in_valid && in_ready;

  // Both index buses carry the same per-lane iteration; the masks tell the
  // controller which of the two views a lane belongs to.
  assign fl_enable_ch = fl_mask;
  assign nr_enable_ch = nr_mask;
  assign fl_it_out    = lane_iters;
  assign nr_it_out    = lane_iters;

  // Only lanes already holding a word take part in the comparison, so lane 0
  // of each batch always comes out unique.
  window_matcher #(
    .WORD_WIDTH (WORD_WIDTH),
    .LANES      (STEP_RANGE)
  ) u_matcher (
    .word         (in_word),
    .stored_words (lane_words),
    .fill_mask    (filled),
    .match        (match)
  );

  // Batch state machine: fill lanes, wait for the controller, hold the batch
  // while it is consumed, then clear and start the next batch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_FILL;
      enable_out <= 1'b0;
      lane_cnt   <= '0;
      iter_cnt   <= '0;
      lane_words <= '0;
      filled     <= '0;
      fl_mask    <= '0;
      nr_mask    <= '0;
      lane_iters <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            for (int i = 0; i < STEP_RANGE; i++) begin
              if (lane_cnt == LANE_W'(i)) begin
                lane_words[i*WORD_WIDTH +: WORD_WIDTH] <= in_word;
                lane_iters[i*ITER_WIDTH +: ITER_WIDTH] <= iter_cnt;
                filled[i]  <= 1'b1;
                fl_mask[i] <= match;
                nr_mask[i] <= !match;
              end
            end
            lane_cnt <= lane_cnt + 1'b1;
            iter_cnt <= iter_cnt + 1'b1;
          end
          // A flush on an empty batch has nothing to issue and is ignored.
          if ((accept && (lane_cnt == LANE_W'(STEP_RANGE - 1))) ||
              (flush_req && (lane_cnt != '0))) begin
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ctrl_available) begin
            enable_out <= 1'b1;
            state      <= ST_HANDOFF;
          end
        end
        ST_HANDOFF: begin
          if (!ctrl_available) begin
            enable_out <= 1'b0;
            lane_cnt   <= '0;
            lane_words <= '0;
            filled     <= '0;
            fl_mask    <= '0;
            nr_mask    <= '0;
            lane_iters <= '0;
            state      <= ST_FILL;
          end
        end
        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

endmodule
